nxs_keccak_result_filter: RTL and testbench
===========================================

// Module: nxs_keccak_result_filter
// PURPOSE
// - Sits directly downstream of the 3-block Keccak-f1600 miner pipeline. It consumes the 64-bit hash word that
//   the pipeline emits each cycle and carries each nonce alongside its hash in a delay line.
// - Compares each hash against a 64-bit share target and queues winning nonces in a small FIFO for the host.
// - Keeps hash and overflow counters.
// PARAMETERS
// - PIPE_LATENCY  72  cycles from pipeline input sample to matching hash_in; sets the nonce/valid delay-line length
// - FIFO_DEPTH    8   winning-nonce FIFO entries; must be a power of two, >=2
// - CNT_W         48  width of hash_count
// PORTS
// - clk            in   1   sole clock
// - rst            in   1   synchronous, active-high reset
// - in_valid       in   1   a work item enters the Keccak pipeline this cycle
// - in_nonce       in   32  nonce of that work item
// - hash_in        in   64  Keccak pipeline output word, the pipeline's qword 6
// - target_wr      in   1   load target_in into the target register
// - target_in      in   64  share target; a hash wins when hash < target, unsigned
// - flush          in   1   discard in-flight items and queued results (new work)
// - res_valid      out  1   res_nonce is valid
// - res_ready      in   1   consumer accepts res_nonce
// - res_nonce      out  32  winning nonce, FIFO head
// - hash_count     out  CNT_W  hashes compared since reset/flush
// - overflow_count out  16  winners dropped because the FIFO was full; saturates at 16'hFFFF
// - armed          out  1   target loaded; comparisons enabled
// BEHAVIOUR
// - Reset: all delay-line valid bits=0, FIFO empty, res_valid=0, res_nonce=0, hash_count=0, overflow_count=0,
//   armed=0, target=64'hFFFF_FFFF_FFFF_FFFF.
// - State machine, 2 states:
//   - DISARMED -> ARMED on target_wr.
//   - ARMED -> DISARMED only on rst.
//   - target_wr while ARMED updates the target on the next edge. Items whose compare occurs in the same cycle
//     use the old target.
// - Delay line: {in_valid, in_nonce} enters stage 0 at the edge ending cycle t. It leaves stage PIPE_LATENCY-1
//   in cycle t+PIPE_LATENCY, aligned with hash_in for that nonce.
// - Compare stage, registered, in cycle t+PIPE_LATENCY:
//   - a valid item with armed=1 is counted (hash_count+1, wraps modulo 2^CNT_W);
//   - win = (hash_in < target), strict unsigned 64-bit.
//   - The registered win pushes the nonce into the FIFO at the edge ending cycle t+PIPE_LATENCY+1.
//   - Total latency from in_valid to res_valid is PIPE_LATENCY+2 cycles when the FIFO was empty.
// - Items that are valid while DISARMED are neither counted nor compared.
// - FIFO: first-word-fall-through. res_nonce always shows the head; res_valid = !empty.
//   - Pop on res_valid & res_ready.
//   - Push and pop in the same cycle are both honoured, including when the FIFO is full: the push succeeds and
//     nothing is dropped.
//   - Push while full with no pop: the winner is dropped and overflow_count increments (saturating).
//   - Pop while empty is ignored.
//   - Pointers wrap modulo FIFO_DEPTH. A separate count distinguishes full from empty.
// - flush, synchronous:
//   - on the next edge it clears all delay-line valid bits, the compare-stage valid, the FIFO, hash_count and
//     overflow_count;
//   - the target and armed are kept;
//   - in_valid asserted in the same cycle as flush is discarded.
// - rst has priority over flush; flush has priority over push/pop.
// - Reset asserted mid-operation returns every output to its reset value on the next edge and loses in-flight items.
// CONFIGURATION
// - NXS_RESULT_HASH_OUT_EN defined:
//   - the FIFO entry widens to 96 bits {hash, nonce};
//   - adds port res_hash out 64, the hash of the head entry, reset 0;
//   - res_hash moves in lockstep with res_nonce.
// - NXS_RESULT_HASH_OUT_EN undefined: res_hash is absent and the FIFO stores only 32-bit nonces. All other
//   behaviour is identical.
// TESTING
// - Delay check: rst, target_wr with target=64'h0000_0000_FFFF_FFFF; in_valid nonce=32'h1234 at cycle 10;
//   hash_in=64'h10 at cycle 82 -> res_valid=1 and res_nonce=32'h1234 at cycle 84; hash_count=1.
// - Boundary compare: hash_in==target -> no push. hash_in==target-1 -> push.
//   DISARMED with hash_in=0 -> no push and hash_count stays 0.
// - Overflow: FIFO_DEPTH+3 consecutive winners with res_ready=0 -> FIFO holds the first 8 nonces in order;
//   overflow_count=3.
// - Full with simultaneous pop: FIFO full, res_ready=1 while a winner arrives -> count stays 8 and
//   overflow_count is unchanged. Drain order matches arrival order.
// - Flush/reset mid-flight: 20 items in flight, then flush -> no res_valid for 80 cycles, hash_count=0,
//   armed stays 1. Repeat with rst -> armed=0 and target=all-ones.
// - With NXS_RESULT_HASH_OUT_EN: winner with hash 64'hABCD -> res_hash=64'hABCD together with its nonce.

Source files
------------

// File: rtl/nxs_keccak_result_filter.sv
// Keccak miner result filter: nonce delay line, share-target compare, winning-nonce FIFO and counters.
// Define NXS_RESULT_HASH_OUT_EN to store {hash, nonce} per FIFO entry and expose res_hash.

// Generic first-word-fall-through FIFO with synchronous flush; head reads 0 while empty.
// Latency: a pushed entry is visible at the head the cycle after its write edge.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module nxs_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   input  logic         pop_rdy,
   output logic [W-1:0] head_dat,
   output logic         empty,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign empty    = (cnt == '0);
   assign full     = (cnt == (AW+1)'(DEPTH));
   assign do_pop   = pop_rdy & ~empty;
   // When full, a same-cycle pop frees the slot the push overwrites.
   assign do_push  = push_vld & (~full | do_pop);
   assign head_dat = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush) mem[wr_ptr] <= push_dat;
   end
endmodule

// Delays nonces to meet their hashes, keeps those below the target, queues them for the host.
// Latency: PIPE_LATENCY+2 cycles from in_valid to res_valid with an empty FIFO.
// Backpressure: res_ready stalls the FIFO; winners arriving while it is full and not popping are dropped and counted.
module nxs_keccak_result_filter #(
   parameter int PIPE_LATENCY = 72,
   parameter int FIFO_DEPTH   = 8,
   parameter int CNT_W        = 48
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [31:0]      in_nonce,
   input  logic [63:0]      hash_in,
   input  logic             target_wr,
   input  logic [63:0]      target_in,
   input  logic             flush,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_nonce,
`ifdef NXS_RESULT_HASH_OUT_EN
   output logic [63:0]      res_hash,
`endif
   output logic [CNT_W-1:0] hash_count,
   output logic [15:0]      overflow_count,
   output logic             armed
);
`ifdef NXS_RESULT_HASH_OUT_EN
   typedef struct packed {
      logic [63:0] hash;
      logic [31:0] nonce;
   } entry_t;
`else
   typedef struct packed {
      logic [31:0] nonce;
   } entry_t;
`endif

   typedef enum logic {DISARMED, ARMED} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [63:0]             target;
   logic [PIPE_LATENCY-1:0] dl_vld;
   logic [31:0]             dl_nonce [PIPE_LATENCY];
   logic                    item_vld;
   logic                    cmp_vld;
   entry_t                  cmp_ent;
   entry_t                  head_ent;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    drop_vld;

   always_ff @(posedge clk) begin
      if (rst) state <= DISARMED;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      armed     = 1'b0;
      case (state)
         DISARMED: if (target_wr) state_nxt = ARMED;
         ARMED:    armed = 1'b1;
         default:  state_nxt = DISARMED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)            target <= '1;
      else if (target_wr) target <= target_in;
   end

   // Flush also swallows an in_valid presented in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || flush) dl_vld <= '0;
      else              dl_vld <= {dl_vld[PIPE_LATENCY-2:0], in_valid};
   end

   always_ff @(posedge clk) begin
      dl_nonce[0] <= in_nonce;
      for (int i = 1; i < PIPE_LATENCY; i++) dl_nonce[i] <= dl_nonce[i-1];
   end

   assign item_vld = dl_vld[PIPE_LATENCY-1] & armed;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cmp_vld    <= 1'b0;
         hash_count <= '0;
      end else begin
         cmp_vld <= item_vld & (hash_in < target);
         if (item_vld) hash_count <= hash_count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      cmp_ent.nonce <= dl_nonce[PIPE_LATENCY-1];
`ifdef NXS_RESULT_HASH_OUT_EN
      cmp_ent.hash  <= hash_in;
`endif
   end

   nxs_fifo #(
      .W     ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push_vld (cmp_vld),
      .push_dat (cmp_ent),
      .pop_rdy  (res_ready),
      .head_dat (head_ent),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   assign res_valid = ~fifo_empty;
   assign res_nonce = head_ent.nonce;
`ifdef NXS_RESULT_HASH_OUT_EN
   assign res_hash  = head_ent.hash;
`endif

   assign drop_vld = cmp_vld & fifo_full & ~res_ready;

   always_ff @(posedge clk) begin
      if (rst || flush)                           overflow_count <= '0;
      else if (drop_vld && overflow_count != '1)  overflow_count <= overflow_count + 16'd1;
   end
endmodule

// File: tb/tb_nxs_keccak_result_filter.sv
// Directed bench for nxs_keccak_result_filter: latency, compare boundaries, overflow, flush and reset.
module tb_nxs_keccak_result_filter;
   localparam int PL = 72;
   localparam logic [63:0] T = 64'h0000_0000_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst, in_valid, target_wr, flush, res_ready;
   logic [31:0] in_nonce;
   logic [63:0] hash_in, target_in;
   logic        res_valid, armed;
   logic [31:0] res_nonce;
   logic [47:0] hash_count;
   logic [15:0] overflow_count;
`ifdef NXS_RESULT_HASH_OUT_EN
   logic [63:0] res_hash;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [63:0] hash_at [int];

   nxs_keccak_result_filter dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_nonce(in_nonce), .hash_in(hash_in),
      .target_wr(target_wr), .target_in(target_in), .flush(flush), .res_valid(res_valid),
      .res_ready(res_ready), .res_nonce(res_nonce),
`ifdef NXS_RESULT_HASH_OUT_EN
      .res_hash(res_hash),
`endif
      .hash_count(hash_count), .overflow_count(overflow_count), .armed(armed)
   );

   always #5 clk = ~clk;

   // Plays the role of the Keccak pipeline: emits each scheduled hash PL cycles after its nonce.
   initial begin
      hash_in = '1;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         if (hash_at.exists(cyc)) hash_in = hash_at[cyc];
         else                     hash_in = '1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] n, input logic [63:0] h);
      in_valid = 1'b1;
      in_nonce = n;
      hash_at[cyc + PL] = h;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pop();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0h want 0", res_valid); end
      checks++; if (res_nonce !== 32'h0) begin errors++; $display("FAIL reset_res_nonce: got %0h want 0", res_nonce); end
      checks++; if (hash_count !== 48'h0) begin errors++; $display("FAIL reset_hash_count: got %0h want 0", hash_count); end
      checks++; if (overflow_count !== 16'h0) begin errors++; $display("FAIL reset_overflow: got %0h want 0", overflow_count); end
      checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %0h want 0", armed); end
   endtask

   task automatic test_disarmed();
      send(32'h55, 64'h0);
      repeat (76) tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL disarmed_push: got res_valid %0h want 0", res_valid); end
      checks++; if (hash_count !== 48'h0) begin errors++; $display("FAIL disarmed_count: got %0h want 0", hash_count); end
   endtask

   task automatic test_delay();
      target_in = T;
      target_wr = 1'b1;
      tick();
      target_wr = 1'b0;
      checks++; if (armed !== 1'b1) begin errors++; $display("FAIL arm: got %0h want 1", armed); end
      send(32'h1234, 64'h10);
      repeat (PL) tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL delay_early: got res_valid %0h want 0 at +73", res_valid); end
      checks++; if (hash_count !== 48'd1) begin errors++; $display("FAIL delay_count: got %0d want 1", hash_count); end
      tick();
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL delay_valid: got %0h want 1 at +74", res_valid); end
      checks++; if (res_nonce !== 32'h1234) begin errors++; $display("FAIL delay_nonce: got %0h want 1234", res_nonce); end
      pop();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL delay_pop: got res_valid %0h want 0", res_valid); end
   endtask

   task automatic test_boundary();
      send(32'hA, T);
      send(32'hB, T - 64'd1);
      repeat (73) tick();
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bound_valid: got %0h want 1", res_valid); end
      checks++; if (res_nonce !== 32'hB) begin errors++; $display("FAIL bound_nonce: got %0h want b", res_nonce); end
      checks++; if (hash_count !== 48'd3) begin errors++; $display("FAIL bound_count: got %0d want 3", hash_count); end
      pop();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bound_equal_pushed: got res_valid %0h want 0", res_valid); end
   endtask

   task automatic test_overflow();
      do_flush();
      for (int i = 0; i < 11; i++) send(32'h100 + i, 64'h1);
      repeat (76) tick();
      checks++; if (overflow_count !== 16'd3) begin errors++; $display("FAIL ovf_count: got %0d want 3", overflow_count); end
      checks++; if (hash_count !== 48'd11) begin errors++; $display("FAIL ovf_hash_count: got %0d want 11", hash_count); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (res_valid !== 1'b1 || res_nonce !== 32'h100 + i) begin
            errors++; $display("FAIL ovf_drain%0d: got v=%0h n=%0h want v=1 n=%0h", i, res_valid, res_nonce, 32'h100 + i);
         end
         pop();
      end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got res_valid %0h want 0", res_valid); end
   endtask

   task automatic test_full_pop();
      do_flush();
      for (int i = 0; i < 9; i++) send(32'h200 + i, 64'h2);
      repeat (72) tick();
      checks++; if (res_nonce !== 32'h200) begin errors++; $display("FAIL fullpop_head: got %0h want 200", res_nonce); end
      pop();
      checks++; if (overflow_count !== 16'd0) begin errors++; $display("FAIL fullpop_ovf: got %0d want 0", overflow_count); end
      for (int i = 1; i < 9; i++) begin
         checks++;
         if (res_valid !== 1'b1 || res_nonce !== 32'h200 + i) begin
            errors++; $display("FAIL fullpop_drain%0d: got v=%0h n=%0h want v=1 n=%0h", i, res_valid, res_nonce, 32'h200 + i);
         end
         pop();
      end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got res_valid %0h want 0", res_valid); end
   endtask

`ifdef NXS_RESULT_HASH_OUT_EN
   task automatic test_hash_out();
      do_flush();
      send(32'h77, 64'hABCD);
      repeat (73) tick();
      checks++; if (res_nonce !== 32'h77) begin errors++; $display("FAIL hash_out_nonce: got %0h want 77", res_nonce); end
      checks++; if (res_hash !== 64'hABCD) begin errors++; $display("FAIL hash_out_hash: got %0h want abcd", res_hash); end
      pop();
   endtask
`endif

   task automatic test_target_update();
      do_flush();
      send(32'h400, 64'h5);
      repeat (PL - 1) tick();
      target_in = 64'h5;
      target_wr = 1'b1;
      tick();
      target_wr = 1'b0;
      tick();
      checks++; if (res_valid !== 1'b1 || res_nonce !== 32'h400) begin errors++; $display("FAIL tgt_old: got v=%0h n=%0h want v=1 n=400", res_valid, res_nonce); end
      pop();
      send(32'h401, 64'h5);
      send(32'h402, 64'h4);
      repeat (75) tick();
      checks++; if (res_valid !== 1'b1 || res_nonce !== 32'h402) begin errors++; $display("FAIL tgt_new: got v=%0h n=%0h want v=1 n=402", res_valid, res_nonce); end
      pop();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL tgt_new_empty: got res_valid %0h want 0", res_valid); end
   endtask

   task automatic test_flush_reset();
      int seen;
      do_flush();
      for (int i = 0; i < 20; i++) send(32'h300 + i, 64'h1);
      flush = 1'b1;
      in_valid = 1'b1;
      in_nonce = 32'h3FF;
      hash_at[cyc + PL] = 64'h1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         if (res_valid === 1'b1) seen++;
         tick();
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL flush_results: got %0d cycles valid want 0", seen); end
      checks++; if (hash_count !== 48'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", hash_count); end
      checks++; if (armed !== 1'b1) begin errors++; $display("FAIL flush_armed: got %0h want 1", armed); end
      send(32'h3AA, 64'h1);
      repeat (73) tick();
      checks++; if (res_valid !== 1'b1 || res_nonce !== 32'h3AA) begin errors++; $display("FAIL flush_target_kept: got v=%0h n=%0h want v=1 n=3aa", res_valid, res_nonce); end
      for (int i = 0; i < 20; i++) send(32'h500 + i, 64'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (armed !== 1'b0) begin errors++; $display("FAIL rst_armed: got %0h want 0", armed); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %0h want 0", res_valid); end
      target_in = T;
      target_wr = 1'b1;
      tick();
      target_wr = 1'b0;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         if (res_valid === 1'b1) seen++;
         tick();
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_results: got %0d cycles valid want 0", seen); end
      checks++; if (hash_count !== 48'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", hash_count); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_nonce = '0; target_wr = 1'b0; target_in = '0;
      flush = 1'b0; res_ready = 1'b0;
      test_reset();
      test_disarmed();
      test_delay();
      test_boundary();
      test_overflow();
      test_full_pop();
`ifdef NXS_RESULT_HASH_OUT_EN
      test_hash_out();
`endif
      test_target_update();
      test_flush_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
